imem_resp: RTL and testbench

IMEM_RESP -- requirements
Module: imem_resp

---
 rtl/imem_resp.sv | 113 +++++++++++
 tb/tb_imem_resp.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_resp.sv
// imem_resp: in-order instruction fetch response queue in front of a pipelined backing memory.
// Optional one-entry response hit buffer is enabled by defining IMEM_RESP_HITBUF_EN.
module imem_resp #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_DATA = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic        MEM_WAIT,
  output logic        INST_RVALID,
  output logic [31:0] INST_ROADDR,
  output logic [31:0] INST_RDATA,
  output logic        MEM_RREQ,
  output logic [31:0] MEM_RADDR,
  input  logic        MEM_RREADY,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam ptr_t PTR_FULL = ptr_t'(DEPTH);

  ptr_t        wr_ptr, iss_ptr, rd_ptr, drop_cnt;
  ptr_t        count;
  logic [31:0] addr_q [DEPTH];
  logic [31:0] fetch_addr, rd_addr, hit_data;
  logic        full, req_vld, hit, accept, issue, ret, deliver;
  logic        unused_addr_lsb;

  always_comb begin
    fetch_addr      = {INST_RIADDR[31:2], 2'b00};
    unused_addr_lsb = ^INST_RIADDR[1:0];
    count           = wr_ptr - rd_ptr;
    full            = (count == PTR_FULL);
    req_vld         = INST_RDEN & ~FLUSH;
    rd_addr         = addr_q[rd_ptr[IW-1:0]];
    ret             = MEM_RVALID & (iss_ptr != rd_ptr);
    deliver         = ret & (drop_cnt == '0) & ~FLUSH;
    MEM_WAIT        = req_vld & full;
    MEM_RREQ        = (iss_ptr != wr_ptr) & ~FLUSH;
    MEM_RADDR       = addr_q[iss_ptr[IW-1:0]];
    issue           = MEM_RREQ & MEM_RREADY;
    accept          = req_vld & ~full & ~hit;
  end

`ifdef IMEM_RESP_HITBUF_EN
  logic        hb_valid;
  logic [31:0] hb_addr, hb_data;

  always_comb begin
    hit      = req_vld & (count == '0) & (drop_cnt == '0) & hb_valid & (hb_addr == fetch_addr);
    hit_data = hb_data;
  end

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      hb_valid <= 1'b0;
    end else if (deliver) begin
      hb_valid <= 1'b1;
      hb_addr  <= rd_addr;
      hb_data  <= MEM_RDATA;
    end
  end
`else
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RST && accept) addr_q[wr_ptr[IW-1:0]] <= fetch_addr;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr      <= '0;
      iss_ptr     <= '0;
      rd_ptr      <= '0;
      drop_cnt    <= '0;
      INST_RVALID <= 1'b0;
      INST_ROADDR <= '0;
      INST_RDATA  <= NOP_DATA;
    end else begin
      rd_ptr  <= rd_ptr + ptr_t'(ret);
      iss_ptr <= iss_ptr + ptr_t'(issue);
      if (FLUSH) begin
        wr_ptr   <= iss_ptr;
        // Entries already pending drop lie inside iss-rd, so recount instead of accumulating.
        drop_cnt <= (iss_ptr - rd_ptr) - ptr_t'(ret);
      end else begin
        wr_ptr <= wr_ptr + ptr_t'(accept);
        if (ret && drop_cnt != '0) drop_cnt <= drop_cnt - PTR_ONE;
      end
      INST_RVALID <= deliver | hit;
      if (FLUSH) begin
        INST_ROADDR <= '0;
        INST_RDATA  <= NOP_DATA;
      end else if (deliver) begin
        INST_ROADDR <= rd_addr;
        INST_RDATA  <= MEM_RDATA;
      end else if (hit) begin
        INST_ROADDR <= fetch_addr;
        INST_RDATA  <= hit_data;
      end
    end
  end
endmodule

// File: tb/tb_imem_resp.sv
// Randomized scoreboard bench for imem_resp: a queue-level fetch model predicts responses,
// a bench memory answers issued reads in order, and a monitor pops and compares each response.
module tb_imem_resp;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_RESP_HITBUF_EN
  localparam bit HB = 1'b1;
`else
  localparam bit HB = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, FLUSH, INST_RDEN, MEM_RREADY;
  logic [31:0] INST_RIADDR;
  logic        MEM_RVALID = 1'b0;
  logic [31:0] MEM_RDATA  = '0;
  logic        MEM_WAIT, INST_RVALID, MEM_RREQ;
  logic [31:0] INST_ROADDR, INST_RDATA, MEM_RADDR;

  always #5 CLK = ~CLK;

  imem_resp #(.DEPTH(DEPTH), .NOP_DATA(NOP)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR),
    .MEM_WAIT(MEM_WAIT), .INST_RVALID(INST_RVALID), .INST_ROADDR(INST_ROADDR),
    .INST_RDATA(INST_RDATA), .MEM_RREQ(MEM_RREQ), .MEM_RADDR(MEM_RADDR),
    .MEM_RREADY(MEM_RREADY), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA)
  );

  typedef struct { logic [31:0] addr; bit issued; bit dropped; } ent_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } rsp_t;
  typedef struct { logic [31:0] addr; int unsigned due; } pend_t;

  ent_t  mq[$];        // accepted fetches not yet retired, oldest first
  rsp_t  exp_q[$];     // responses the DUT must still deliver
  pend_t mem_pend[$];  // reads the bench memory owes
  int    checks = 0, errors = 0;
  int unsigned cyc = 0, lat_max = 1, spur_pct = 0;
  bit    mem_hold = 1'b0, force_stray = 1'b0;
  bit    hb_v = 1'b0;
  logic [31:0] hb_a = '0, hb_d = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h2000_0000) return 32'h0000_0093;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int unsigned limit);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || mq.size() != 0) && n < limit) begin
      step();
      n++;
    end
    chk1("drain_done", (exp_q.size() == 0 && mq.size() == 0), 1'b1);
    step();
  endtask

  // Reference model: evaluates the coming edge from the stable inputs of this cycle.
  always @(negedge CLK) begin : model
    int   size0, u;
    bit   rreq_e, ret;
    ent_t head, ne;
    pend_t p;
    rsp_t r;
    logic [31:0] fa;
    size0 = mq.size();
    u = -1;
    for (int i = 0; i < size0; i++) if (u < 0 && !mq[i].issued) u = i;
    chk1("mem_wait", MEM_WAIT, INST_RDEN && !FLUSH && size0 == DEPTH);
    rreq_e = !FLUSH && (u >= 0);
    chk1("mem_rreq", MEM_RREQ, rreq_e);
    if (rreq_e) chk("mem_raddr", MEM_RADDR, mq[u].addr);
    if (RST) begin
      mq.delete();
      mem_pend.delete();
      hb_v = 1'b0;
    end else begin
      ret = MEM_RVALID && size0 > 0 && mq[0].issued;
      fa  = {INST_RIADDR[31:2], 2'b00};
      if (rreq_e && MEM_RREADY) begin
        mq[u].issued = 1'b1;
        p.addr = MEM_RADDR;
        p.due  = cyc + $urandom_range(lat_max, 1);
        mem_pend.push_back(p);
      end
      if (!FLUSH && INST_RDEN && HB && hb_v && size0 == 0 && hb_a == fa) begin
        r.addr = fa; r.data = hb_d;
        exp_q.push_back(r);
      end else if (!FLUSH && INST_RDEN && size0 < DEPTH) begin
        ne.addr = fa; ne.issued = 1'b0; ne.dropped = 1'b0;
        mq.push_back(ne);
      end
      if (ret) begin
        head = mq.pop_front();
        if (!head.dropped && !FLUSH) begin
          r.addr = head.addr; r.data = memf(head.addr);
          exp_q.push_back(r);
          hb_v = 1'b1; hb_a = head.addr; hb_d = r.data;
        end
      end
      if (FLUSH) begin
        for (int i = int'(mq.size()) - 1; i >= 0; i--) begin
          if (!mq[i].issued) mq.delete(i);
          else mq[i].dropped = 1'b1;
        end
        hb_v = 1'b0;
      end
    end
  end

  // Bench memory: answers issued reads in order after their latency, optional stray pulses.
  always @(posedge CLK) begin : responder
    pend_t p;
    #1;
    cyc++;
    MEM_RVALID = 1'b0;
    MEM_RDATA  = $urandom;
    if (mem_pend.size() > 0) begin
      if (!mem_hold && mem_pend[0].due <= cyc) begin
        p = mem_pend.pop_front();
        MEM_RVALID = 1'b1;
        MEM_RDATA  = memf(p.addr);
      end
    end else if (force_stray || $urandom_range(99) < spur_pct) begin
      MEM_RVALID = 1'b1;
    end
  end

  // Monitor: every delivered response must match the head of the scoreboard.
  always @(posedge CLK) begin : monitor
    rsp_t r;
    #1;
    if (INST_RVALID) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got addr %h data %h, expected no response (t=%0t)",
                 INST_ROADDR, INST_RDATA, $time);
      end else begin
        r = exp_q.pop_front();
        chk("rsp_addr", INST_ROADDR, r.addr);
        chk("rsp_data", INST_RDATA, r.data);
      end
    end
  end

  initial begin
    logic [31:0] pc;
    bit taken;
    RST = 1'b1; FLUSH = 1'b0; INST_RDEN = 1'b0; INST_RIADDR = '0; MEM_RREADY = 1'b1;
    step(); step();
    chk1("rst_rvalid", INST_RVALID, 1'b0);
    chk("rst_roaddr", INST_ROADDR, 32'h0);
    chk("rst_rdata", INST_RDATA, NOP);
    chk1("rst_rreq", MEM_RREQ, 1'b0);
    RST = 1'b0;

    // single fetch, one-cycle memory latency
    lat_max = 1;
    INST_RDEN = 1'b1; INST_RIADDR = 32'h2000_0000;
    step(); INST_RDEN = 1'b0;
    chk1("lat_c1", INST_RVALID, 1'b0);
    step();
    chk1("lat_c2", INST_RVALID, 1'b0);
    step();
    chk1("lat_c3", INST_RVALID, 1'b1);
    chk("lat_addr", INST_ROADDR, 32'h2000_0000);
    chk("lat_data", INST_RDATA, 32'h0000_0093);
    drain(50);

    // backpressure: queue fills at DEPTH, then drains in order
    FLUSH = 1'b1; step(); FLUSH = 1'b0;
    lat_max = 4; MEM_RREADY = 1'b0; pc = 32'h2000_0000;
    for (int i = 0; i < 6; i++) begin
      INST_RDEN = 1'b1; INST_RIADDR = pc | $urandom_range(3);
      #1;
      chk1("bp_wait", MEM_WAIT, i >= 4);
      if (!MEM_WAIT) pc = pc + 32'd4;
      step();
    end
    INST_RDEN = 1'b0; MEM_RREADY = 1'b1;
    drain(100);

    // flush with three reads in flight
    mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      INST_RDEN = 1'b1; INST_RIADDR = 32'h3000_0000 + 32'(i * 4);
      step();
    end
    INST_RDEN = 1'b0;
    step();
    FLUSH = 1'b1; INST_RDEN = 1'b1; INST_RIADDR = 32'h3000_0100;
    step();
    FLUSH = 1'b0; INST_RDEN = 1'b0;
    chk1("fl_rvalid", INST_RVALID, 1'b0);
    chk("fl_roaddr", INST_ROADDR, 32'h0);
    chk("fl_rdata", INST_RDATA, NOP);
    mem_hold = 1'b0;
    drain(50);
    INST_RDEN = 1'b1; INST_RIADDR = 32'h3000_0200;
    step(); INST_RDEN = 1'b0;
    drain(50);

    // reset with two reads in flight, then a stray memory response
    mem_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      INST_RDEN = 1'b1; INST_RIADDR = 32'h4000_0000 + 32'(i * 4);
      step();
    end
    INST_RDEN = 1'b0;
    step();
    RST = 1'b1; step(); RST = 1'b0;
    chk1("mr_rvalid", INST_RVALID, 1'b0);
    chk("mr_roaddr", INST_ROADDR, 32'h0);
    chk("mr_rdata", INST_RDATA, NOP);
    chk1("mr_rreq", MEM_RREQ, 1'b0);
    chk1("mr_wait", MEM_WAIT, 1'b0);
    mem_hold = 1'b0; force_stray = 1'b1;
    step(); force_stray = 1'b0;
    step();
    chk1("mr_stray", INST_RVALID, 1'b0);
    INST_RDEN = 1'b1; INST_RIADDR = 32'h4000_0040;
    step(); INST_RDEN = 1'b0;
    drain(50);

`ifdef IMEM_RESP_HITBUF_EN
    INST_RDEN = 1'b1; INST_RIADDR = 32'h2000_0010;
    step(); INST_RDEN = 1'b0;
    drain(50);
    INST_RDEN = 1'b1; INST_RIADDR = 32'h2000_0012;
    step(); INST_RDEN = 1'b0;
    chk1("hb_hit", INST_RVALID, 1'b1);
    chk1("hb_norreq", MEM_RREQ, 1'b0);
    FLUSH = 1'b1; step(); FLUSH = 1'b0;
    INST_RDEN = 1'b1; INST_RIADDR = 32'h2000_0010;
    step(); INST_RDEN = 1'b0;
    chk1("hb_miss_rreq", MEM_RREQ, 1'b1);
    drain(50);
`endif

    // randomized traffic
    spur_pct = 20; pc = 32'h2000_0000;
    for (int c = 0; c < 3000; c++) begin
      RST         = ($urandom_range(499) == 0);
      FLUSH       = ($urandom_range(39) == 0);
      INST_RDEN   = ($urandom_range(99) < 70);
      MEM_RREADY  = ($urandom_range(99) < 70);
      INST_RIADDR = pc | $urandom_range(3);
      @(negedge CLK);
      taken = INST_RDEN && !FLUSH && !RST && !MEM_WAIT;
      step();
      if (FLUSH || RST || (taken && $urandom_range(9) == 0))
        pc = 32'h2000_0000 + ($urandom_range(15) << 2);
      else if (taken)
        pc = pc + 32'd4;
    end
    RST = 1'b0; FLUSH = 1'b0; INST_RDEN = 1'b0; MEM_RREADY = 1'b1; spur_pct = 0;
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
